// File: rtl/card_sym_pkg.sv
// Shared types for the card symbol renderer and the card colour mux.
// Shape selector and animation state encodings live here.
package card_sym_pkg;

  localparam int SHAPE_W = 2;

  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_VBAR  = 2'd0,
    SHAPE_PLUS  = 2'd1,
    SHAPE_BOX   = 2'd2,
    SHAPE_XDIAG = 2'd3
  } shape_e;

  typedef enum logic [1:0] {
    ANIM_HIDDEN    = 2'd0,
    ANIM_GROWING   = 2'd1,
    ANIM_SHOWN     = 2'd2,
    ANIM_SHRINKING = 2'd3
  } anim_state_e;

endpackage

// File: rtl/sym_anim_fsm.sv
// Reveal/hide animation FSM: owns cur_size and steps it once per frame_tick
// toward the full symbol size or toward zero.
module sym_anim_fsm
  import card_sym_pkg::*;
#(
  parameter int CW   = 10,
  parameter int STEP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          reveal,
  input  logic          hide,
  input  logic [CW-1:0] size,
  output logic [CW-1:0] cur_size,
  output logic          shown,
  output logic          busy
);

  localparam logic [CW:0] STEP_W = (CW+1)'(STEP);

  anim_state_e   state_q, state_d, reqState;
  logic [CW-1:0] cur_size_q, cur_size_d;
  logic [CW:0]   grown;
  logic [CW:0]   shrunkWide;
  logic [CW-1:0] shrunk;
  logic          revealReq, hideReq;

  // Opposing requests in the same cycle cancel each other out.
  assign revealReq  = reveal & ~hide;
  assign hideReq    = hide & ~reveal;
  assign grown      = {1'b0, cur_size_q} + STEP_W;
  assign shrunkWide = ({1'b0, cur_size_q} > STEP_W) ? ({1'b0, cur_size_q} - STEP_W) : '0;
  assign shrunk     = shrunkWide[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ANIM_HIDDEN;
      cur_size_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_size_q <= cur_size_d;
    end
  end

  // The request is resolved first so that a coincident tick uses the new state's rule.
  always_comb begin
    reqState = state_q;
    case (state_q)
      ANIM_HIDDEN, ANIM_SHRINKING: if (revealReq) reqState = ANIM_GROWING;
      ANIM_GROWING, ANIM_SHOWN:    if (hideReq)   reqState = ANIM_SHRINKING;
      default: ;
    endcase

    state_d    = reqState;
    cur_size_d = cur_size_q;
    if (frame_tick) begin
      case (reqState)
        ANIM_GROWING: begin
          if (grown >= {1'b0, size}) begin
            cur_size_d = size;
            state_d    = ANIM_SHOWN;
          end else begin
            cur_size_d = grown[CW-1:0];
          end
        end
        ANIM_SHOWN: cur_size_d = size;
        ANIM_SHRINKING: begin
          cur_size_d = shrunk;
          if (shrunk == '0) state_d = ANIM_HIDDEN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_size = cur_size_q;
    shown    = (state_q == ANIM_SHOWN);
    busy     = (state_q == ANIM_GROWING) || (state_q == ANIM_SHRINKING);
  end

endmodule

// File: rtl/card_symbol_renderer.sv
// Two-stage per-pixel hit test for one animated card symbol.
// Stage 1 reduces the pixel to centre distances, stage 2 applies the shape rule.
module card_symbol_renderer
  import card_sym_pkg::*;
#(
  parameter int CW   = 10,
  parameter int STEP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  input  logic [CW-1:0] size,
  input  logic [CW-1:0] t,
  input  shape_e        shape,
  input  logic          frame_tick,
  input  logic          reveal,
  input  logic          hide,
  output logic          in_sym,
  output logic          in_valid,
  output logic          shown,
  output logic          busy
);

  localparam int AW = CW + 3;

  logic [CW-1:0] curSize;

  sym_anim_fsm #(
    .CW   (CW),
    .STEP (STEP)
  ) u_anim (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .reveal     (reveal),
    .hide       (hide),
    .size       (size),
    .cur_size   (curSize),
    .shown      (shown),
    .busy       (busy)
  );

  logic signed [AW-1:0] dx, dy, ax, ay, hs, ht, boxLo;

  assign dx    = $signed({3'b000, x}) - $signed({3'b000, cx});
  assign dy    = $signed({3'b000, y}) - $signed({3'b000, cy});
  assign ax    = (dx < 0) ? -dx : dx;
  assign ay    = (dy < 0) ? -dy : dy;
  assign hs    = $signed({4'b0000, curSize[CW-1:1]});
  assign ht    = $signed({4'b0000, t[CW-1:1]});
  // Inner edge of the box ring; goes non-positive when t > hs, which fills the box.
  assign boxLo = hs - $signed({3'b000, t}) + AW'(1);

  logic signed [AW-1:0] ax_q, ay_q, hs_q, ht_q, boxLo_q;
  shape_e               shape_q;
  logic                 sizeNz_q, valid1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_q     <= '0;
      ay_q     <= '0;
      hs_q     <= '0;
      ht_q     <= '0;
      boxLo_q  <= '0;
      shape_q  <= SHAPE_VBAR;
      sizeNz_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      ax_q     <= ax;
      ay_q     <= ay;
      hs_q     <= hs;
      ht_q     <= ht;
      boxLo_q  <= boxLo;
      shape_q  <= shape;
      sizeNz_q <= (curSize != '0);
      valid1_q <= pix_valid;
    end
  end

  logic signed [AW-1:0] maxA, diff, absDiff;
  logic                 inVbar, inHbar, hit;

  assign maxA    = (ax_q > ay_q) ? ax_q : ay_q;
  assign diff    = ax_q - ay_q;
  assign absDiff = (diff < 0) ? -diff : diff;
  assign inVbar  = (ax_q <= ht_q) && (ay_q <= hs_q);
  assign inHbar  = (ay_q <= ht_q) && (ax_q <= hs_q);

  always_comb begin
    hit = 1'b0;
    case (shape_q)
      SHAPE_VBAR:  hit = inVbar;
      SHAPE_PLUS:  hit = inVbar || inHbar;
      SHAPE_BOX:   hit = (maxA <= hs_q) && (maxA >= boxLo_q);
      SHAPE_XDIAG: hit = (absDiff <= ht_q) && (maxA <= hs_q);
      default:     hit = 1'b0;
    endcase
  end

  logic in_sym_q, in_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sym_q   <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in_sym_q   <= valid1_q && sizeNz_q && hit;
      in_valid_q <= valid1_q;
    end
  end

  assign in_sym   = in_sym_q;
  assign in_valid = in_valid_q;

endmodule

// File: tb/tb_card_symbol_renderer.sv
// Randomized and directed bench for card_symbol_renderer against an
// arithmetic reference model of the animation and hit-test rules.
module tb_card_symbol_renderer;
  import card_sym_pkg::*;

  localparam int CW   = 10;
  localparam int STEP = 4;

  localparam int M_HIDDEN    = 0;
  localparam int M_GROWING   = 1;
  localparam int M_SHOWN     = 2;
  localparam int M_SHRINKING = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid;
  logic [CW-1:0] x, y, cx, cy, size, t;
  shape_e        shape;
  logic          frame_tick, reveal, hide;
  logic          in_sym, in_valid, shown, busy;

  int checks = 0;
  int errors = 0;

  int mState;
  int mSize;
  bit pipeV[2];
  bit pipeHit[2];

  card_symbol_renderer #(
    .CW   (CW),
    .STEP (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .cx         (cx),
    .cy         (cy),
    .size       (size),
    .t          (t),
    .shape      (shape),
    .frame_tick (frame_tick),
    .reveal     (reveal),
    .hide       (hide),
    .in_sym     (in_sym),
    .in_valid   (in_valid),
    .shown      (shown),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit refHit(int px, int py, int ccx, int ccy, int sz, int th, int shp);
    int ax, ay, hs, ht, m, d;
    bit r;
    ax = (px > ccx) ? px - ccx : ccx - px;
    ay = (py > ccy) ? py - ccy : ccy - py;
    hs = sz / 2;
    ht = th / 2;
    m  = (ax > ay) ? ax : ay;
    d  = (ax > ay) ? ax - ay : ay - ax;
    case (shp)
      0:       r = (ax <= ht && ay <= hs);
      1:       r = (ax <= ht && ay <= hs) || (ay <= ht && ax <= hs);
      2:       r = (m <= hs) && (m >= hs - th + 1);
      default: r = (d <= ht) && (m <= hs);
    endcase
    return (sz != 0) && r;
  endfunction

  task automatic modelReset();
    mState = M_HIDDEN;
    mSize  = 0;
    pipeV   = '{0, 0};
    pipeHit = '{0, 0};
  endtask

  task automatic checkAll();
    checkOutput("in_valid", int'(in_valid), int'(pipeV[1]));
    checkOutput("in_sym",   int'(in_sym),   int'(pipeHit[1]));
    checkOutput("shown",    int'(shown),    int'(mState == M_SHOWN));
    checkOutput("busy",     int'(busy),     int'(mState == M_GROWING || mState == M_SHRINKING));
    checkOutput("cur_size", int'(dut.u_anim.cur_size), mSize);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input bit pv, input int px, input int py, input int shp,
                               input bit tick, input bit rev, input bit hid);
    bit newHit;
    bit r, h;
    pix_valid  = pv;
    x          = CW'(px);
    y          = CW'(py);
    shape      = shape_e'(shp[1:0]);
    frame_tick = tick;
    reveal     = rev;
    hide       = hid;
    @(posedge clk);
    newHit     = pv && refHit(px, py, int'(cx), int'(cy), mSize, int'(t), shp);
    pipeV[1]   = pipeV[0];
    pipeHit[1] = pipeHit[0];
    pipeV[0]   = pv;
    pipeHit[0] = newHit;
    r = rev && !hid;
    h = hid && !rev;
    if (r && (mState == M_HIDDEN || mState == M_SHRINKING)) mState = M_GROWING;
    else if (h && (mState == M_GROWING || mState == M_SHOWN)) mState = M_SHRINKING;
    if (tick) begin
      if (mState == M_GROWING) begin
        mSize = (mSize + STEP < int'(size)) ? mSize + STEP : int'(size);
        if (mSize == int'(size)) mState = M_SHOWN;
      end else if (mState == M_SHOWN) begin
        mSize = int'(size);
      end else if (mState == M_SHRINKING) begin
        mSize = (mSize > STEP) ? mSize - STEP : 0;
        if (mSize == 0) mState = M_HIDDEN;
      end
    end
    #1;
    checkAll();
  endtask

  task automatic idle(input bit tick, input bit rev, input bit hid);
    applyStimulus(1'b0, 0, 0, 0, tick, rev, hid);
  endtask

  task automatic probe(input string tag, input int px, input int py, input int shp, input int exp);
    applyStimulus(1'b1, px, py, shp, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, shp, 1'b0, 1'b0, 1'b0);
    checkOutput(tag, int'(in_sym), exp);
  endtask

  initial begin
    int n;
    pix_valid = 0; x = 0; y = 0;
    cx = 10'd320; cy = 10'd240; size = 10'd30; t = 10'd3;
    shape = SHAPE_VBAR; frame_tick = 0; reveal = 0; hide = 0;
    modelReset();
    #3;
    checkOutput("rst_in_sym", int'(in_sym), 0);
    checkOutput("rst_shown",  int'(shown),  0);
    checkOutput("rst_busy",   int'(busy),   0);
    @(negedge clk);
    rst_n = 1'b1;

    probe("hidden_pix", 320, 240, 0, 0);
    checkOutput("hidden_valid", int'(in_valid), 1);

    idle(0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      idle(1, 0, 0);
      checkOutput("grow_size", int'(dut.u_anim.cur_size), (i * 4 < 30) ? i * 4 : 30);
    end
    checkOutput("grown_shown", int'(shown), 1);
    checkOutput("grown_busy",  int'(busy),  0);

    probe("vbar_in",   321, 255, 0, 1);
    probe("vbar_out",  322, 240, 0, 0);
    probe("plus_in",   335, 241, 1, 1);
    probe("box_ctr",   320, 240, 2, 0);
    probe("box_edge",  335, 226, 2, 1);
    probe("xdiag_in",  330, 250, 3, 1);
    probe("xdiag_out", 330, 240, 3, 0);

    idle(0, 0, 1);
    n = 0;
    while (busy && n < 20) begin
      idle(1, 0, 0);
      n++;
    end
    checkOutput("hide_done_busy", int'(busy), 0);
    checkOutput("hide_done_size", int'(dut.u_anim.cur_size), 0);

    idle(0, 1, 0);
    repeat (3) idle(1, 0, 0);
    checkOutput("grow12", int'(dut.u_anim.cur_size), 12);
    idle(0, 0, 1);
    checkOutput("shrinking_busy", int'(busy), 1);
    repeat (3) idle(1, 0, 0);
    checkOutput("shrunk_size", int'(dut.u_anim.cur_size), 0);
    checkOutput("shrunk_busy", int'(busy), 0);

    idle(0, 1, 1);
    checkOutput("both_req_busy", int'(busy), 0);
    idle(1, 1, 0);
    checkOutput("rev_tick_size", int'(dut.u_anim.cur_size), 4);
    checkOutput("rev_tick_busy", int'(busy), 1);

    repeat (3) idle(1, 0, 0);
    checkOutput("grow16", int'(dut.u_anim.cur_size), 16);
    applyStimulus(1'b1, 320, 240, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 320, 240, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_sym",   int'(in_sym),   0);
    checkOutput("mid_rst_in_valid", int'(in_valid), 0);
    checkOutput("mid_rst_busy",     int'(busy),     0);
    checkOutput("mid_rst_shown",    int'(shown),    0);
    checkOutput("mid_rst_size",     int'(dut.u_anim.cur_size), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 1, 0);
    idle(1, 0, 0);
    checkOutput("restart_size", int'(dut.u_anim.cur_size), 4);

    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        size = CW'($urandom_range(0, 60));
        t    = CW'($urandom_range(0, 9));
      end
      applyStimulus(($urandom_range(0, 3) != 0),
                    320 + int'($urandom_range(0, 80)) - 40,
                    240 + int'($urandom_range(0, 80)) - 40,
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
